// File: rtl/mfcc_context_feeder_pkg.sv
// Shared constants for the MFCC front end, this context feeder and the
// word-detect DNN, plus the stream FSM state type used by the feeder.
// No ports (package).
package mfcc_context_feeder_pkg;

  localparam int MFCC_DW    = 20;  // coefficient / DNN input word width
  localparam int MFCC_NCOEF = 13;  // coefficients per frame
  localparam int DNN_CTX    = 5;   // frames per context window
  localparam int DNN_IN_GAP = 21;  // cycles between DNN input words

  // Address width of a context store holding ctx+1 frames of ncoef words.
  function automatic int ctx_addr_w(input int ctx, input int ncoef);
    return $clog2((ctx + 1) * ncoef);
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_READ     = 2'd1,
    ST_WAIT_GAP = 2'd2
  } stream_state_t;

endpackage

// File: rtl/mfcc_context_feeder_context_ram.sv
// Simple dual-port frame store: one write port, one read port with a
// registered read that only updates when re=1, so rdata holds its value
// between reads. The array has no reset; the read register does.
// Ports: clk, rst (async, active-high, read register only),
//        we/waddr/wdata (write), re/raddr (read request), rdata (read data).
module context_ram #(
  parameter int DW    = 20,
  parameter int DEPTH = 78,
  parameter int AW    = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/mfcc_context_feeder.sv
// Collects MFCC frames into a ring of CTX+1 frame slots and, after every
// completed frame once CTX frames are held, streams the CTX most recent
// frames (oldest first, coef 0..NCOEF-1) to the DNN, one word every GAP
// cycles.
// Ports: clk, reset (async, active-high)
//        coef_in/coef_dv          - incoming coefficients
//        vec_out/dv_out           - context word stream to the DNN
//        frame_start              - marks the first word of a window
//        busy                     - window stream in progress
//        overrun                  - pulse when an input coefficient is dropped
module mfcc_context_feeder
  import mfcc_context_feeder_pkg::*;
#(
  parameter int DW    = MFCC_DW,
  parameter int NCOEF = MFCC_NCOEF,
  parameter int CTX   = DNN_CTX,
  parameter int GAP   = DNN_IN_GAP
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] coef_in,
  input  logic          coef_dv,
  output logic [DW-1:0] vec_out,
  output logic          dv_out,
  output logic          frame_start,
  output logic          busy,
  output logic          overrun
);

  localparam int NSLOT = CTX + 1;
  localparam int DEPTH = NSLOT * NCOEF;
  localparam int AW    = ctx_addr_w(CTX, NCOEF);
  localparam int SW    = $clog2(NSLOT);
  localparam int CW    = $clog2(NCOEF);
  localparam int TOTAL = CTX * NCOEF;
  localparam int WW    = $clog2(TOTAL + 1);
  localparam int GW    = $clog2(GAP);
  localparam int FW    = $clog2(CTX + 1);

  localparam logic [SW-1:0] LAST_SLOT = SW'(CTX);
  localparam logic [CW-1:0] LAST_COEF = CW'(NCOEF - 1);
  localparam logic [WW-1:0] TOTAL_W   = WW'(TOTAL);
  localparam logic [FW-1:0] CTX_F     = FW'(CTX);
  // READ cycle plus GAP-1 wait cycles; the counter runs GAP-2 down to 0.
  localparam logic [GW-1:0] GAP_LOAD  = GW'(GAP - 2);

  function automatic logic [SW-1:0] slot_inc(input logic [SW-1:0] s);
    return (s == LAST_SLOT) ? '0 : s + 1'b1;
  endfunction

  // Write side
  logic [SW-1:0] wslot_reg;
  logic [CW-1:0] cidx_reg;
  logic [FW-1:0] fcount_reg;
  // Read side
  stream_state_t state_reg;
  logic [SW-1:0] rslot_reg;
  logic [CW-1:0] ridx_reg;
  logic [WW-1:0] wcnt_reg;
  logic [GW-1:0] gap_reg;
  logic          pending_reg;

  logic          drop, accept, frame_done, trigger, stream_last, restart;
  logic [SW-1:0] wslot_next, oldest_slot;
  logic [FW-1:0] fcount_next;
  logic [AW-1:0] waddr, raddr;
  logic          re;

  // Once a further frame is pending behind a running stream, the only slot
  // free for writing is the one being read, so new input must be dropped.
  assign drop        = coef_dv && pending_reg && busy;
  assign accept      = coef_dv && !drop;
  assign frame_done  = accept && (cidx_reg == LAST_COEF);
  assign wslot_next  = frame_done ? slot_inc(wslot_reg) : wslot_reg;
  // The slot after the next write slot is the oldest of the CTX most recent
  // complete frames (the ring has exactly one spare slot).
  assign oldest_slot = slot_inc(wslot_next);
  assign fcount_next = (frame_done && fcount_reg != CTX_F) ? fcount_reg + 1'b1 : fcount_reg;
  assign trigger     = frame_done && (fcount_next == CTX_F) && !busy;
  // First WAIT_GAP cycle after the final READ is the last dv_out cycle.
  assign stream_last = (state_reg == ST_WAIT_GAP) && (wcnt_reg == TOTAL_W);
  // A frame finishing on the last dv_out cycle is treated like a pending one.
  assign restart     = stream_last && (pending_reg || frame_done);

  assign waddr = AW'(wslot_reg) * AW'(NCOEF) + AW'(cidx_reg);
  assign raddr = AW'(rslot_reg) * AW'(NCOEF) + AW'(ridx_reg);
  assign re    = (state_reg == ST_READ);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wslot_reg  <= '0;
      cidx_reg   <= '0;
      fcount_reg <= '0;
    end else begin
      if (accept) cidx_reg <= frame_done ? '0 : cidx_reg + 1'b1;
      wslot_reg  <= wslot_next;
      fcount_reg <= fcount_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      rslot_reg   <= '0;
      ridx_reg    <= '0;
      wcnt_reg    <= '0;
      gap_reg     <= '0;
      pending_reg <= 1'b0;
      busy        <= 1'b0;
      dv_out      <= 1'b0;
      frame_start <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      dv_out      <= 1'b0;
      frame_start <= 1'b0;
      overrun     <= drop;

      if (restart)                 pending_reg <= 1'b0;
      else if (frame_done && busy) pending_reg <= 1'b1;

      case (state_reg)
        ST_IDLE: begin
          if (trigger) begin
            state_reg <= ST_READ;
            busy      <= 1'b1;
            rslot_reg <= oldest_slot;
            ridx_reg  <= '0;
            wcnt_reg  <= '0;
          end
        end
        ST_READ: begin
          dv_out      <= 1'b1;
          frame_start <= (wcnt_reg == '0);
          wcnt_reg    <= wcnt_reg + 1'b1;
          gap_reg     <= GAP_LOAD;
          state_reg   <= ST_WAIT_GAP;
          if (ridx_reg == LAST_COEF) begin
            ridx_reg  <= '0;
            rslot_reg <= slot_inc(rslot_reg);
          end else begin
            ridx_reg  <= ridx_reg + 1'b1;
          end
        end
        ST_WAIT_GAP: begin
          if (stream_last) begin
            if (restart) begin
              // busy stays high: the next window follows back to back
              state_reg <= ST_READ;
              rslot_reg <= oldest_slot;
              ridx_reg  <= '0;
              wcnt_reg  <= '0;
            end else begin
              state_reg <= ST_IDLE;
              busy      <= 1'b0;
            end
          end else if (gap_reg == '0) begin
            state_reg <= ST_READ;
          end else begin
            gap_reg <= gap_reg - 1'b1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  context_ram #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .rst   (reset),
    .we    (accept),
    .waddr (waddr),
    .wdata (coef_in),
    .re    (re),
    .raddr (raddr),
    .rdata (vec_out)
  );

endmodule
